// File: rtl/uart_rx_sipo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sipo
// Purpose  : UART receive serial-in/parallel-out stage. Oversamples the
//            serial line and recovers frames made of a start bit (0),
//            DATA_BITS data bits (LSB first), an optional even-parity bit,
//            and one stop bit (1). The recovered byte is offered on a
//            valid/ready handshake. Framing, parity and overrun errors are
//            reported as one-clk pulses.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   OVERSAMPLE  baud_tick pulses per bit period (even, >= 4)
//   DATA_BITS   data bits per frame (5..8)
// Build option
//   UART_RX_PARITY_EN  when defined, a parity bit follows the data bits and
//                      the PARITY state is compiled in; otherwise parity_err
//                      is tied low.
// Ports
//   clk          system clock
//   rst          asynchronous, active-low reset
//   baud_tick    one-clk strobe at OVERSAMPLE x baud rate
//   rx_in        asynchronous serial line, idle high
//   data_out     received byte, stable while data_valid is high
//   data_valid   data_out holds an unconsumed byte
//   data_ready   consumer accepts data_out when data_valid is also high
//   frame_err    one-clk pulse: stop bit sampled low
//   parity_err   one-clk pulse: parity mismatch
//   overrun_err  one-clk pulse: good frame dropped, previous byte unconsumed
//   busy         high whenever the receiver is not idle
// ============================================================================
module uart_rx_sipo #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t                 state, state_n;
    logic [TW-1:0]          tick_cnt, tick_n;
    logic [BW-1:0]          bit_cnt, bit_n;
    logic [DATA_BITS-1:0]   shreg, shreg_n;
    logic [DATA_BITS-1:0]   data_out_n;
    logic                   data_valid_n;
    logic                   frame_err_n;
    logic                   overrun_err_n;
    logic                   frame_good;
    logic                   sync1;
    logic                   rxs;
    logic                   at_half;
    logic                   at_centre;

`ifdef UART_RX_PARITY_EN
    logic                   par_bad, par_bad_n;
    logic                   parity_err_n;
`endif

    // ------------------------------------------------------------------
    // Two-flop synchronizer; resets to the idle (high) line level so a
    // reset never looks like a start bit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rxs   <= sync1;
        end
    end

    // START samples half a bit in so every later sample lands mid-bit.
    assign at_half   = baud_tick && (tick_cnt == HALF_TICK);
    assign at_centre = baud_tick && (tick_cnt == FULL_TICK);

    // ------------------------------------------------------------------
    // Next-state, datapath and handshake logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n       = state;
        tick_n        = tick_cnt;
        bit_n         = bit_cnt;
        shreg_n       = shreg;
        frame_good    = 1'b0;
        frame_err_n   = 1'b0;
        overrun_err_n = 1'b0;
        data_out_n    = data_out;
        data_valid_n  = data_valid;
`ifdef UART_RX_PARITY_EN
        par_bad_n     = par_bad;
        parity_err_n  = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_n = START;
                    tick_n  = '0;
                end
            end

            START: begin
                if (at_half) begin
                    if (rxs) begin
                        // Line went back high before mid-start: a glitch.
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                        tick_n  = '0;
                        bit_n   = '0;
`ifdef UART_RX_PARITY_EN
                        par_bad_n = 1'b0;
`endif
                    end
                end else if (baud_tick) begin
                    tick_n = tick_cnt + 1'b1;
                end
            end

            DATA: begin
                if (at_centre) begin
                    // LSB arrives first, so shift right and enter at MSB.
                    shreg_n = {rxs, shreg[DATA_BITS-1:1]};
                    tick_n  = '0;
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end else if (baud_tick) begin
                    tick_n = tick_cnt + 1'b1;
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (at_centre) begin
                    // Even parity: data bits plus parity bit XOR to zero.
                    par_bad_n = ^{shreg, rxs};
                    tick_n    = '0;
                    state_n   = STOP;
                end else if (baud_tick) begin
                    tick_n = tick_cnt + 1'b1;
                end
            end
`endif

            STOP: begin
                if (at_centre) begin
                    tick_n = '0;
                    if (!rxs) begin
                        frame_err_n = 1'b1;
                        state_n     = BREAK;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad) begin
                        parity_err_n = 1'b1;
                        state_n      = IDLE;
`endif
                    end else begin
                        frame_good = 1'b1;
                        state_n    = IDLE;
                    end
                end else if (baud_tick) begin
                    tick_n = tick_cnt + 1'b1;
                end
            end

            BREAK: begin
                // Hold off until the line is released so a long low
                // level is not taken as a new start bit.
                if (rxs) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // A consume on the same edge as a good frame frees the buffer, so
        // the new byte loads without an overrun.
        if (frame_good) begin
            if (!data_valid || data_ready) begin
                data_out_n   = shreg;
                data_valid_n = 1'b1;
            end else begin
                overrun_err_n = 1'b1;
            end
        end else if (data_valid && data_ready) begin
            data_valid_n = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state       <= state_n;
            tick_cnt    <= tick_n;
            bit_cnt     <= bit_n;
            shreg       <= shreg_n;
            data_out    <= data_out_n;
            data_valid  <= data_valid_n;
            frame_err   <= frame_err_n;
            overrun_err <= overrun_err_n;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bad    <= par_bad_n;
            parity_err <= parity_err_n;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sipo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_sipo
// Purpose  : Self-checking bench for uart_rx_sipo (OVERSAMPLE=16,
//            DATA_BITS=8). A table of frames is sent and compared, followed
//            by hand-written sequences for glitch, overrun, same-edge
//            consume, parity (when UART_RX_PARITY_EN is defined) and
//            mid-frame reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_sipo;

    localparam int OS       = 16;
    localparam int DB       = 8;
    localparam int BIT_CLKS = 2 * OS;   // baud_tick fires every other clk
`ifdef UART_RX_PARITY_EN
    localparam int STOP_TICK = OS / 2 + OS * (DB + 2);
`else
    localparam int STOP_TICK = OS / 2 + OS * (DB + 1);
`endif

    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic          baud_tick  = 1'b0;
    logic          rx_in      = 1'b1;
    logic          data_ready = 1'b0;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          frame_err;
    logic          parity_err;
    logic          overrun_err;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int fe_cnt, pe_cnt, ov_cnt, dv_rise, dv_fall, coinc;
    logic dv_prev = 1'b0;
    int n;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_rise;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [6];

    uart_rx_sipo #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_tick   (baud_tick),
        .rx_in       (rx_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        baud_tick = ~baud_tick;
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_err)   fe_cnt++;
        if (parity_err)  pe_cnt++;
        if (overrun_err) ov_cnt++;
        if (data_valid && !dv_prev) begin
            dv_rise++;
            if (frame_err || parity_err || overrun_err) coinc++;
        end
        if (!data_valid && dv_prev) dv_fall++;
        dv_prev = data_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_counts();
        @(posedge clk);
        fe_cnt  = 0;
        pe_cnt  = 0;
        ov_cnt  = 0;
        dv_rise = 0;
        dv_fall = 0;
    endtask

    task automatic hold_bit(input logic b);
        rx_in = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_good);
        @(negedge clk);
        hold_bit(1'b0);
        for (int i = 0; i < DB; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        hold_bit(par_good ? ^d : ~^d);
`endif
        hold_bit(stop);
    endtask

    task automatic consume();
        @(negedge clk);
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
    endtask

    initial begin
        coinc = 0;
        vecs[0] = '{8'hA5, 1'b1, 1, 0};
        vecs[1] = '{8'h3C, 1'b0, 0, 1};
        vecs[2] = '{8'h55, 1'b1, 1, 0};
        vecs[3] = '{8'h00, 1'b1, 1, 0};
        vecs[4] = '{8'hFF, 1'b1, 1, 0};
        vecs[5] = '{8'h80, 1'b1, 1, 0};

        // ---------------- reset values ----------------
        repeat (4) @(negedge clk);
        check("rst_data_out",    32'(data_out),    32'h0);
        check("rst_data_valid",  32'(data_valid),  32'h0);
        check("rst_frame_err",   32'(frame_err),   32'h0);
        check("rst_parity_err",  32'(parity_err),  32'h0);
        check("rst_overrun_err", 32'(overrun_err), 32'h0);
        check("rst_busy",        32'(busy),        32'h0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // ---------------- table-driven frames ----------------
        for (int v = 0; v < 6; v++) begin
            clr_counts();
            send_frame(vecs[v].data, vecs[v].stop, 1'b1);
            if (!vecs[v].stop) begin
                repeat (80) @(negedge clk);   // 40 more ticks of held-low line
                check("break_busy", 32'(busy), 32'h1);
                check("break_no_valid", 32'(dv_rise), 32'h0);
                rx_in = 1'b1;
            end
            repeat (40) @(negedge clk);
            check("vec_busy_idle", 32'(busy), 32'h0);
            check("vec_valid_rise", 32'(dv_rise), 32'(vecs[v].exp_rise));
            if (vecs[v].exp_rise == 1) begin
                check("vec_data_out", 32'(data_out), 32'(vecs[v].data));
            end
            check("vec_frame_err", 32'(fe_cnt), 32'(vecs[v].exp_ferr));
            check("vec_parity_err", 32'(pe_cnt), 32'h0);
            check("vec_overrun", 32'(ov_cnt), 32'h0);
            consume();
            check("vec_consumed", 32'(data_valid), 32'h0);
        end

        // ---------------- start-bit glitch ----------------
        clr_counts();
        @(negedge clk);
        rx_in = 1'b0;
        repeat (10) @(negedge clk);        // 5 ticks low
        check("glitch_start_busy", 32'(busy), 32'h1);
        rx_in = 1'b1;
        repeat (60) @(negedge clk);
        check("glitch_idle", 32'(busy), 32'h0);
        check("glitch_no_valid", 32'(dv_rise), 32'h0);
        check("glitch_no_ferr", 32'(fe_cnt), 32'h0);

        // ---------------- overrun ----------------
        clr_counts();
        send_frame(8'h11, 1'b1, 1'b1);
        repeat (40) @(negedge clk);
        check("ovr_first_valid", 32'(data_valid), 32'h1);
        check("ovr_first_data", 32'(data_out), 32'h11);
        send_frame(8'h22, 1'b1, 1'b1);
        repeat (40) @(negedge clk);
        check("ovr_pulse", 32'(ov_cnt), 32'h1);
        check("ovr_data_kept", 32'(data_out), 32'h11);
        check("ovr_valid_kept", 32'(data_valid), 32'h1);
        consume();
        check("ovr_consumed", 32'(data_valid), 32'h0);

        // ---------------- consume on the completing edge ----------------
        clr_counts();
        send_frame(8'h11, 1'b1, 1'b1);
        repeat (40) @(negedge clk);
        check("same_first_valid", 32'(data_valid), 32'h1);
        clr_counts();
        fork
            send_frame(8'h22, 1'b1, 1'b1);
            begin
                n = 0;
                @(negedge rx_in);
                repeat (3) @(posedge clk);   // synchronizer + IDLE->START edge
                while (n < STOP_TICK - 1) begin
                    @(posedge clk);
                    if (baud_tick) n++;
                end
                @(negedge clk);
                @(negedge clk);
                data_ready = 1'b1;           // present for the stop-centre tick
                @(negedge clk);
                data_ready = 1'b0;
            end
        join
        repeat (40) @(negedge clk);
        check("same_data_new", 32'(data_out), 32'h22);
        check("same_valid_high", 32'(data_valid), 32'h1);
        check("same_no_overrun", 32'(ov_cnt), 32'h0);
        check("same_valid_no_drop", 32'(dv_fall), 32'h0);
        consume();

`ifdef UART_RX_PARITY_EN
        // ---------------- parity ----------------
        clr_counts();
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (40) @(negedge clk);
        check("par_good_valid", 32'(dv_rise), 32'h1);
        check("par_good_data", 32'(data_out), 32'h07);
        check("par_good_no_err", 32'(pe_cnt), 32'h0);
        consume();
        clr_counts();
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (40) @(negedge clk);
        check("par_bad_pulse", 32'(pe_cnt), 32'h1);
        check("par_bad_no_valid", 32'(dv_rise), 32'h0);
        check("par_bad_idle", 32'(busy), 32'h0);
`endif

        // ---------------- reset mid-frame ----------------
        send_frame(8'h5A, 1'b1, 1'b1);
        repeat (40) @(negedge clk);
        check("mid_pre_valid", 32'(data_valid), 32'h1);
        @(negedge clk);
        rx_in = 1'b0;
        repeat (3 * BIT_CLKS) @(negedge clk);
        check("mid_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(data_valid), 32'h0);
        check("mid_rst_data", 32'(data_out), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_errs", 32'({frame_err, parity_err, overrun_err}), 32'h0);
        rx_in = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        clr_counts();
        repeat (BIT_CLKS * 12) @(negedge clk);
        check("mid_after_no_valid", 32'(dv_rise), 32'h0);
        check("mid_after_no_ferr", 32'(fe_cnt + pe_cnt + ov_cnt), 32'h0);
        check("mid_after_idle", 32'(busy), 32'h0);

        check("err_vs_valid_rise", 32'(coinc), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
